// File: rtl/cpu_control_pkg.sv
// Shared definitions for the 4-bit CPU sequencer: instruction ops, ALU opcodes and FSM states.
package cpu_control_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_PASS = 4'hF;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOT  = 4'b0100;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_control_pc.sv
// Program counter: jump load has priority over increment; increment wraps mod 2**PC_W.
module cpu_control_pc #(
    parameter int PC_W     = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_W'(RESET_PC);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// Fetch/execute sequencer and accumulator for the 4-bit CPU; drives the external ALU.
//
//  state | meaning
//  IDLE  | waiting for run
//  FETCH | imem_req high, PC on imem_addr until imem_ack
//  EXEC  | one cycle: drive ALU, commit acc/flags, advance or jump PC
//  HALT  | halted high, no requests until reset
module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int PC_W     = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_opcode,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    input  logic [3:0]      alu_result,
    input  logic            alu_carry,
    input  logic            alu_zero,
    output logic [3:0]      acc,
    output logic            carry_flag,
    output logic            zero_flag,
    output logic            halted
);

    state_e          state;
    logic [7:0]      ir;
    logic [3:0]      op;
    logic [3:0]      imm;
    logic            pc_load;
    logic            pc_inc;
    logic [PC_W-1:0] pc;

    assign op        = ir[7:4];
    assign imm       = ir[3:0];
    assign imem_addr = pc;

    // Jumps test the flags as they stood before this EXEC commits.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (state == ST_EXEC) begin
            case (op)
                OP_JMP:  pc_load = 1'b1;
                OP_JZ:   begin pc_load = zero_flag;  pc_inc = !zero_flag;  end
                OP_JC:   begin pc_load = carry_flag; pc_inc = !carry_flag; end
                OP_HALT: ;
                default: pc_inc = 1'b1;
            endcase
        end
    end

    cpu_control_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (PC_W'(imm)),
        .pc       (pc)
    );

    always_comb begin
        alu_opcode = ALU_PASS;
        alu_a      = acc;
        alu_b      = 4'h0;
        if (state == ST_EXEC) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                    alu_opcode = op;
                    alu_b      = imm;
                end
                OP_LDI:  alu_a = imm;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ir         <= 8'h00;
            acc        <= 4'h0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b1;
            imem_req   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        state    <= ST_EXEC;
                        imem_req <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                            acc        <= alu_result;
                            carry_flag <= alu_carry;
                            zero_flag  <= alu_zero;
                        end
                        OP_PASS: begin
                            carry_flag <= 1'b0;
                            zero_flag  <= alu_zero;
                        end
                        OP_LDI: begin
                            acc        <= imm;
                            carry_flag <= 1'b0;
                            zero_flag  <= (imm == 4'h0);
                        end
                        default: ;
                    endcase
                    if (op == OP_HALT) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_HALT: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control with an ALU model, a wait-state memory and an ISA-level reference.
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [3:0] alu_opcode, alu_a, alu_b, alu_result;
    logic       alu_carry, alu_zero;
    logic [3:0] acc;
    logic       carry_flag, zero_flag, halted;

    int n_pass = 0;
    int n_checks = 0;

    logic [7:0] mem [16];
    bit  mem_en;
    int  wait_n;
    int  wcnt;
    int  cyc = 0;
    int  last_ack_cyc;

    int  ref_pc, ref_acc;
    bit  ref_c, ref_z, ref_halt;

    cpu_control #(.PC_W(4), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .acc        (acc),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // External ALU model
    always_comb begin
        alu_result = alu_a;
        alu_carry  = 1'b0;
        case (alu_opcode)
            4'h0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h1: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            4'h2: alu_result = alu_a & alu_b;
            4'h3: alu_result = alu_a | alu_b;
            4'h4: alu_result = ~alu_a;
            default: alu_result = alu_a;
        endcase
        alu_zero = (alu_result == 4'h0);
    end

    // Instruction memory with wait_n wait cycles before ack
    initial begin
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (imem_req) begin
                    if (wcnt >= wait_n) begin
                        imem_ack  = 1'b1;
                        imem_data = mem[imem_addr];
                        wcnt      = 0;
                    end else begin
                        imem_ack = 1'b0;
                        wcnt++;
                    end
                end else begin
                    imem_ack = 1'b0;
                    wcnt     = 0;
                end
            end
        end
    end

    task automatic ref_reset();
        ref_pc = 0; ref_acc = 0; ref_c = 0; ref_z = 1; ref_halt = 0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        run    = 1'b0;
        mem_en = 1'b1;
        wait_n = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h90;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_reset();
    endtask

    task automatic start();
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    // Waits for one fetch, applies the ISA-level rules, then compares the committed state.
    task automatic exec_one();
        bit         found = 0;
        logic [7:0] ins;
        int         op, imm, nxt;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (imem_req && imem_ack) found = 1;
        end
        n_checks++;
        if (!found) begin
            $display("FAIL fetch_timeout: no ack within 40 cycles, pc expected %0d", ref_pc);
            return;
        end
        n_pass++;
        last_ack_cyc = cyc;
        n_checks++; if (imem_addr !== 4'(ref_pc)) $display("FAIL fetch_addr: got %0d expected %0d", imem_addr, ref_pc); else n_pass++;
        ins = mem[ref_pc];
        op  = int'(ins[7:4]);
        imm = int'(ins[3:0]);
        nxt = (ref_pc + 1) % 16;
        case (op)
            0: begin ref_c = (ref_acc + imm) > 15; ref_acc = (ref_acc + imm) % 16; ref_z = (ref_acc == 0); end
            1: begin ref_c = ref_acc < imm; ref_acc = (ref_acc - imm + 16) % 16; ref_z = (ref_acc == 0); end
            2: begin ref_c = 0; ref_acc = ref_acc & imm; ref_z = (ref_acc == 0); end
            3: begin ref_c = 0; ref_acc = ref_acc | imm; ref_z = (ref_acc == 0); end
            4: begin ref_c = 0; ref_acc = 15 - ref_acc; ref_z = (ref_acc == 0); end
            5: begin ref_c = 0; ref_acc = imm; ref_z = (imm == 0); end
            6: nxt = imm;
            7: if (ref_z) nxt = imm;
            8: if (ref_c) nxt = imm;
            14: begin ref_halt = 1; nxt = ref_pc; end
            15: begin ref_c = 0; ref_z = (ref_acc == 0); end
            default: ;
        endcase
        ref_pc = nxt;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (acc !== 4'(ref_acc)) $display("FAIL acc ins=%02h: got %0h expected %0h", ins, acc, ref_acc); else n_pass++;
        n_checks++; if (carry_flag !== ref_c) $display("FAIL carry ins=%02h: got %0b expected %0b", ins, carry_flag, ref_c); else n_pass++;
        n_checks++; if (zero_flag !== ref_z) $display("FAIL zero ins=%02h: got %0b expected %0b", ins, zero_flag, ref_z); else n_pass++;
        n_checks++; if (imem_addr !== 4'(ref_pc)) $display("FAIL pc ins=%02h: got %0d expected %0d", ins, imem_addr, ref_pc); else n_pass++;
        n_checks++; if (halted !== ref_halt) $display("FAIL halted ins=%02h: got %0b expected %0b", ins, halted, ref_halt); else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b expected 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 4'h0) $display("FAIL reset_pc: got %0d expected 0", imem_addr); else n_pass++;
        n_checks++; if ({acc, carry_flag, zero_flag, halted} !== 7'b0000_010) $display("FAIL reset_regs: got %07b expected 0000010", {acc, carry_flag, zero_flag, halted}); else n_pass++;
        n_checks++; if ({alu_opcode, alu_a, alu_b} !== 12'hF00) $display("FAIL reset_alu: got %03h expected F00", {alu_opcode, alu_a, alu_b}); else n_pass++;
    endtask

    task automatic test_add_carry();
        do_reset();
        mem[0] = 8'h57;
        mem[1] = 8'h09;
        start();
        exec_one();
        exec_one();
        n_checks++; if ({acc, carry_flag, zero_flag} !== 6'b0000_11) $display("FAIL add_carry: got %06b expected 000011", {acc, carry_flag, zero_flag}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int a;
        do_reset();
        mem[0] = 8'h53;
        mem[1] = 8'h15;
        mem[2] = 8'hF0;
        start();
        exec_one();
        exec_one();
        a = last_ack_cyc;
        n_checks++; if ({acc, carry_flag, zero_flag} !== 6'b1110_10) $display("FAIL sub_borrow: got %06b expected 111010", {acc, carry_flag, zero_flag}); else n_pass++;
        exec_one();
        n_checks++; if (last_ack_cyc - a !== 2) $display("FAIL throughput: got %0d cycles expected 2", last_ack_cyc - a); else n_pass++;
        n_checks++; if ({acc, carry_flag} !== 5'b1110_0) $display("FAIL pass_clears_carry: got %05b expected 11100", {acc, carry_flag}); else n_pass++;
    endtask

    task automatic test_wait_states();
        int cnt = 0;
        bit addr_ok = 1, acc_ok = 1, got = 0;
        do_reset();
        mem[0] = 8'h5A;
        wait_n = 3;
        start();
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (imem_req) begin
                cnt++;
                if (imem_addr !== 4'h0) addr_ok = 0;
                if (acc !== 4'h0) acc_ok = 0;
            end
            if (imem_ack) got = 1;
        end
        n_checks++; if (cnt !== 4) $display("FAIL wait_req_cycles: got %0d expected 4", cnt); else n_pass++;
        n_checks++; if (!addr_ok) $display("FAIL wait_addr_stable: got unstable expected 0"); else n_pass++;
        n_checks++; if (!acc_ok) $display("FAIL wait_acc_early: got changed expected 0"); else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (acc !== 4'hA) $display("FAIL wait_commit: got %0h expected a", acc); else n_pass++;
    endtask

    task automatic test_jumps();
        do_reset();
        mem[0]  = 8'h50;
        mem[1]  = 8'h78;
        mem[8]  = 8'h51;
        mem[9]  = 8'h78;
        mem[10] = 8'h8C;
        mem[11] = 8'h6D;
        mem[13] = 8'hE0;
        start();
        for (int i = 0; i < 7; i++) exec_one();
    endtask

    task automatic test_wrap_halt();
        bit idle_ok = 1;
        do_reset();
        mem[0]  = 8'h7E;
        mem[14] = 8'h51;
        mem[15] = 8'h90;
        mem[1]  = 8'hB0;
        mem[2]  = 8'hE0;
        start();
        for (int i = 0; i < 6; i++) exec_one();
        for (int i = 0; i < 4; i++) begin
            start();
            @(negedge clk);
            #1;
            if (imem_req !== 1'b0 || imem_addr !== 4'h2 || halted !== 1'b1) idle_ok = 0;
        end
        n_checks++; if (!idle_ok) $display("FAIL halt_frozen: got req=%0b pc=%0d halted=%0b expected 0/2/1", imem_req, imem_addr, halted); else n_pass++;
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        mem_en   = 0;
        imem_ack = 1'b0;
        mem[0]   = 8'h57;
        mem[1]   = 8'h58;
        start();
        mem[0] = 8'h5F;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL midfetch_req_before: got %0b expected 1", imem_req); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL midfetch_req_drop: got %0b expected 0", imem_req); else n_pass++;
        n_checks++; if ({imem_addr, acc, carry_flag, zero_flag, halted} !== 11'b0000_0000_010) $display("FAIL midfetch_outputs: got %011b expected 00000000010", {imem_addr, acc, carry_flag, zero_flag, halted}); else n_pass++;
        @(negedge clk);
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 8'h5F;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if ({imem_req, acc, zero_flag} !== 6'b0_0000_1) $display("FAIL stray_ack: got %06b expected 000001", {imem_req, acc, zero_flag}); else n_pass++;
        imem_ack = 1'b0;
        mem_en   = 1;
        mem[0]   = 8'h57;
        ref_reset();
        start();
        exec_one();
        exec_one();
    endtask

    task automatic test_random();
        logic [7:0] ins;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hE) ins[7:4] = 4'h9;
            mem[i] = ins;
        end
        start();
        for (int i = 0; i < 30; i++) begin
            wait_n = $urandom_range(0, 2);
            exec_one();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_en    = 1'b1;
        wait_n    = 0;
        test_reset();
        test_add_carry();
        test_back_to_back();
        test_wait_states();
        test_jumps();
        test_wrap_halt();
        test_reset_midfetch();
        test_random();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
